// File: rtl/ebreak_halt_ctrl.sv
// ebreak_halt_ctrl
//
// Halt controller for a simulated core. It watches the retirement stream for
// an ebreak. When one retires it captures a0 as the exit code and the ebreak
// pc, freezes the pipeline and waits for the LSU to drain. It then offers a
// halt report to the testbench over a valid/ready handshake and parks in
// HALTED until reset.
//
// Parameters
//   XLEN       datapath width of pc and a0
//   DRAIN_MAX  maximum number of DRAIN cycles spent waiting for lsu_busy to clear
//
// Ports
//   clock         sole clock, all state updates on the rising edge
//   reset_n       asynchronous active-low reset
//   commit_valid  one instruction retires this cycle
//   commit_inst   retiring instruction word
//   commit_pc     retiring pc
//   a0            architectural x10, sampled on the ebreak commit
//   lsu_busy      outstanding memory transaction
//   freeze        stall fetch/commit (combinational in the ebreak cycle)
//   halt_valid    halt report offered
//   halt_ready    report accepted
//   halt_code     captured a0
//   halt_pc       captured ebreak pc
//   halt_timeout  drain gave up after DRAIN_MAX cycles with lsu_busy still high
//   cycle_cnt     cycles spent outside HALTED
//   instret_cnt   instructions retired in RUN, including the ebreak
//
// Build option
//   NPC_HALT_PERF_CNT_EN  when defined, builds the two 64-bit perf counters.
//                         When undefined, cycle_cnt and instret_cnt are tied
//                         to zero and no counter flops exist.

module ebreak_halt_ctrl #(
  parameter int XLEN      = 64,
  parameter int DRAIN_MAX = 255
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            commit_valid,
  input  logic [31:0]     commit_inst,
  input  logic [XLEN-1:0] commit_pc,
  input  logic [XLEN-1:0] a0,
  input  logic            lsu_busy,
  output logic            freeze,
  output logic            halt_valid,
  input  logic            halt_ready,
  output logic [XLEN-1:0] halt_code,
  output logic [XLEN-1:0] halt_pc,
  output logic            halt_timeout,
  output logic [63:0]     cycle_cnt,
  output logic [63:0]     instret_cnt
);

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
  // Wide enough to hold DRAIN_MAX itself.
  localparam int CW = $clog2(DRAIN_MAX + 2);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_REPORT = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] halt_code_q, halt_code_d;
  logic [XLEN-1:0] halt_pc_q, halt_pc_d;
  logic            halt_timeout_q, halt_timeout_d;
  logic            halt_valid_q, halt_valid_d;
  logic [CW-1:0]   drain_cnt_q, drain_cnt_d;
  logic [CW-1:0]   drain_inc_s;
  logic            ebreak_s;

  // An ebreak only counts while running; later ones are ignored.
  assign ebreak_s    = (state_q == ST_RUN) && commit_valid && (commit_inst == EBREAK_INST);
  // The count includes the current DRAIN cycle, so the timeout fires on the
  // DRAIN_MAX-th DRAIN cycle.
  assign drain_inc_s = drain_cnt_q + {{(CW-1){1'b0}}, 1'b1};

  // freeze must already be high in the ebreak commit cycle.
  assign freeze       = (state_q != ST_RUN) || ebreak_s;
  assign halt_valid   = halt_valid_q;
  assign halt_code    = halt_code_q;
  assign halt_pc      = halt_pc_q;
  assign halt_timeout = halt_timeout_q;

  // Next-state and capture logic for the halt sequence.
  always_comb begin
    state_d        = state_q;
    halt_code_d    = halt_code_q;
    halt_pc_d      = halt_pc_q;
    halt_timeout_d = halt_timeout_q;
    drain_cnt_d    = drain_cnt_q;
    halt_valid_d   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (ebreak_s) begin
          halt_code_d    = a0;
          halt_pc_d      = commit_pc;
          halt_timeout_d = 1'b0;
          drain_cnt_d    = {CW{1'b0}};
          state_d        = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        drain_cnt_d = drain_inc_s;
        // A drained LSU wins over the timeout in the same cycle.
        if (!lsu_busy) begin
          state_d      = ST_REPORT;
          halt_valid_d = 1'b1;
        end else if (drain_inc_s >= CW'(DRAIN_MAX)) begin
          halt_timeout_d = 1'b1;
          state_d        = ST_REPORT;
          halt_valid_d   = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_REPORT: begin
        if (halt_valid_q && halt_ready) begin
          state_d      = ST_HALTED;
          halt_valid_d = 1'b0;
        end else begin
          halt_valid_d = 1'b1;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Halt controller state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_RUN;
      halt_code_q    <= {XLEN{1'b0}};
      halt_pc_q      <= {XLEN{1'b0}};
      halt_timeout_q <= 1'b0;
      halt_valid_q   <= 1'b0;
      drain_cnt_q    <= {CW{1'b0}};
    end else begin
      state_q        <= state_d;
      halt_code_q    <= halt_code_d;
      halt_pc_q      <= halt_pc_d;
      halt_timeout_q <= halt_timeout_d;
      halt_valid_q   <= halt_valid_d;
      drain_cnt_q    <= drain_cnt_d;
    end
  end

`ifdef NPC_HALT_PERF_CNT_EN
  logic [63:0] cycle_cnt_q, cycle_cnt_d;
  logic [63:0] instret_cnt_q, instret_cnt_d;

  // Perf counter increments; both wrap naturally at 64 bits.
  always_comb begin
    cycle_cnt_d   = cycle_cnt_q;
    instret_cnt_d = instret_cnt_q;
    if (state_q != ST_HALTED) begin
      cycle_cnt_d = cycle_cnt_q + 64'd1;
    end else begin
      cycle_cnt_d = cycle_cnt_q;
    end
    if ((state_q == ST_RUN) && commit_valid) begin
      instret_cnt_d = instret_cnt_q + 64'd1;
    end else begin
      instret_cnt_d = instret_cnt_q;
    end
  end

  // Perf counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt_q   <= 64'd0;
      instret_cnt_q <= 64'd0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`else
  assign cycle_cnt   = 64'd0;
  assign instret_cnt = 64'd0;
`endif

endmodule

// File: tb/tb_ebreak_halt_ctrl.sv
// Testbench for ebreak_halt_ctrl. Two instances are used: one with the
// default DRAIN_MAX, and one with DRAIN_MAX=4 for the drain timeout cases.
// Expected halt reports are queued by the stimulus and checked by a monitor
// on each valid/ready handshake.

module tb_ebreak_halt_ctrl;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef NPC_HALT_PERF_CNT_EN
  localparam logic PERF = 1'b1;
`else
  localparam logic PERF = 1'b0;
`endif

  typedef struct {
    logic [63:0] code;
    logic [63:0] pc;
    logic        to;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // DUT A (DRAIN_MAX default)
  logic        a_rst_n, a_cv, a_busy, a_ready;
  logic [31:0] a_inst;
  logic [63:0] a_pc, a_a0;
  logic        a_freeze, a_hv, a_to;
  logic [63:0] a_code, a_hpc, a_cyc, a_ins;

  // DUT B (DRAIN_MAX = 4)
  logic        b_rst_n, b_cv, b_busy, b_ready;
  logic [31:0] b_inst;
  logic [63:0] b_pc, b_a0;
  logic        b_freeze, b_hv, b_to;
  logic [63:0] b_code, b_hpc, b_cyc, b_ins;

  ebreak_halt_ctrl #(.XLEN(64)) dut_a (
    .clock(clock), .reset_n(a_rst_n), .commit_valid(a_cv), .commit_inst(a_inst),
    .commit_pc(a_pc), .a0(a_a0), .lsu_busy(a_busy), .freeze(a_freeze),
    .halt_valid(a_hv), .halt_ready(a_ready), .halt_code(a_code), .halt_pc(a_hpc),
    .halt_timeout(a_to), .cycle_cnt(a_cyc), .instret_cnt(a_ins)
  );

  ebreak_halt_ctrl #(.XLEN(64), .DRAIN_MAX(4)) dut_b (
    .clock(clock), .reset_n(b_rst_n), .commit_valid(b_cv), .commit_inst(b_inst),
    .commit_pc(b_pc), .a0(b_a0), .lsu_busy(b_busy), .freeze(b_freeze),
    .halt_valid(b_hv), .halt_ready(b_ready), .halt_code(b_code), .halt_pc(b_hpc),
    .halt_timeout(b_to), .cycle_cnt(b_cyc), .instret_cnt(b_ins)
  );

  int   errors = 0;
  int   checks = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard monitor for DUT A: compare on every accepted report.
  always @(negedge clock) begin
    if (a_rst_n && a_hv && a_ready) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_a_unexpected: got report code 0x%0h expected none", a_code);
      end else begin
        ea = qa.pop_front();
        chk("sb_a_code", a_code, ea.code);
        chk("sb_a_pc", a_hpc, ea.pc);
        chk("sb_a_timeout", {63'd0, a_to}, {63'd0, ea.to});
      end
    end
  end

  // Scoreboard monitor for DUT B.
  always @(negedge clock) begin
    if (b_rst_n && b_hv && b_ready) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_b_unexpected: got report code 0x%0h expected none", b_code);
      end else begin
        eb = qb.pop_front();
        chk("sb_b_code", b_code, eb.code);
        chk("sb_b_pc", b_hpc, eb.pc);
        chk("sb_b_timeout", {63'd0, b_to}, {63'd0, eb.to});
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dcyc;
    int hold;
    a_rst_n = 1'b0; a_cv = 1'b0; a_inst = NOP; a_pc = 64'd0; a_a0 = 64'd0;
    a_busy = 1'b0; a_ready = 1'b0;
    b_rst_n = 1'b0; b_cv = 1'b0; b_inst = NOP; b_pc = 64'd0; b_a0 = 64'd0;
    b_busy = 1'b0; b_ready = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_a_freeze", {63'd0, a_freeze}, 64'd0);
    chk("rst_a_valid", {63'd0, a_hv}, 64'd0);
    chk("rst_a_code", a_code, 64'd0);
    chk("rst_a_pc", a_hpc, 64'd0);
    chk("rst_a_timeout", {63'd0, a_to}, 64'd0);
    chk("rst_a_cycle", a_cyc, 64'd0);
    chk("rst_a_instret", a_ins, 64'd0);
    chk("rst_b_valid", {63'd0, b_hv}, 64'd0);
    chk("rst_b_cycle", b_cyc, 64'd0);
    chk("rst_b_instret", b_ins, 64'd0);

    // 10 commits over 20 cycles (one is ecall), then ebreak at 0x8000_0010
    a_rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a_cv   = (i % 2 == 0);
      a_inst = (i == 4) ? ECALL : NOP;
      a_pc   = 64'h8000_0000 + 64'(4 * i);
      #1;
      chk("run_freeze_low", {63'd0, a_freeze}, 64'd0);
      step();
    end
    a_cv = 1'b1; a_inst = EBREAK; a_pc = 64'h8000_0010; a_a0 = 64'd0;
    a_busy = 1'b0; a_ready = 1'b1;
    qa.push_back('{code: 64'd0, pc: 64'h8000_0010, to: 1'b0});
    #1;
    chk("ebreak_freeze_comb", {63'd0, a_freeze}, 64'd1);
    chk("ebreak_valid_low", {63'd0, a_hv}, 64'd0);
    step();
    a_cv = 1'b0; a_inst = NOP;
    chk("drain_valid_low", {63'd0, a_hv}, 64'd0);
    chk("drain_freeze", {63'd0, a_freeze}, 64'd1);
    step();
    chk("report_valid_2cyc", {63'd0, a_hv}, 64'd1);
    step();
    chk("halted_valid_low", {63'd0, a_hv}, 64'd0);
    chk("halted_freeze", {63'd0, a_freeze}, 64'd1);
    a_cv = 1'b1; a_inst = EBREAK; a_a0 = 64'd9;
    step();
    step();
    step();
    a_cv = 1'b0;
    chk("halted_stays", {63'd0, a_hv}, 64'd0);
    chk("halted_code_kept", a_code, 64'd0);
    chk("perf_instret_11", a_ins, PERF ? 64'd11 : 64'd0);
    chk("perf_cycle_frozen", a_cyc, PERF ? 64'd23 : 64'd0);

    // ebreak a0=1, lsu_busy 5 DRAIN cycles, second ebreak in DRAIN, ready held low 3 cycles
    a_rst_n = 1'b0; a_ready = 1'b0;
    step();
    a_rst_n = 1'b1;
    a_cv = 1'b1; a_inst = EBREAK; a_pc = 64'h8000_0100; a_a0 = 64'd1; a_busy = 1'b1;
    qa.push_back('{code: 64'd1, pc: 64'h8000_0100, to: 1'b0});
    step();
    dcyc = 0;
    for (int k = 0; k < 50 && !a_hv; k++) begin
      dcyc++;
      a_busy = (dcyc <= 5);
      a_cv   = (dcyc == 2);
      a_a0   = 64'd7;
      step();
    end
    a_cv = 1'b0; a_inst = NOP;
    chk("busy_drain_cycles", 64'(dcyc), 64'd6);
    chk("second_ebreak_code", a_code, 64'd1);
    chk("second_ebreak_instret", a_ins, PERF ? 64'd1 : 64'd0);
    hold = 0;
    for (int k = 0; k < 20 && a_hv; k++) begin
      hold++;
      a_ready = (hold == 4);
      step();
    end
    a_ready = 1'b0;
    chk("valid_held_cycles", 64'(hold), 64'd4);
    chk("busy_timeout_low", {63'd0, a_to}, 64'd0);

    // Reset in REPORT abandons the report
    a_rst_n = 1'b0;
    step();
    a_rst_n = 1'b1;
    a_cv = 1'b1; a_inst = EBREAK; a_pc = 64'h8000_0200; a_a0 = 64'h22; a_busy = 1'b0;
    step();
    a_cv = 1'b0; a_inst = NOP;
    step();
    chk("pre_rst_valid", {63'd0, a_hv}, 64'd1);
    step();
    a_rst_n = 1'b0;
    #1;
    chk("midrst_valid", {63'd0, a_hv}, 64'd0);
    chk("midrst_freeze", {63'd0, a_freeze}, 64'd0);
    chk("midrst_code", a_code, 64'd0);
    chk("midrst_cycle", a_cyc, 64'd0);
    chk("midrst_instret", a_ins, 64'd0);
    step();
    a_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_cv = 1'b1; a_inst = NOP; a_pc = 64'h8000_0300 + 64'(4 * i);
      #1;
      chk("after_rst_freeze", {63'd0, a_freeze}, 64'd0);
      step();
    end
    a_inst = EBREAK; a_pc = 64'h8000_030c; a_a0 = 64'hDEAD_BEEF_0000_0042; a_ready = 1'b1;
    qa.push_back('{code: 64'hDEAD_BEEF_0000_0042, pc: 64'h8000_030c, to: 1'b0});
    step();
    a_cv = 1'b0; a_inst = NOP;
    step();
    chk("after_rst_report", {63'd0, a_hv}, 64'd1);
    step();
    chk("after_rst_halted", {63'd0, a_hv}, 64'd0);
    chk("after_rst_instret", a_ins, PERF ? 64'd4 : 64'd0);
    chk("after_rst_cycle", a_cyc, PERF ? 64'd6 : 64'd0);
    a_ready = 1'b0;

    // DUT B: lsu_busy stuck high -> timeout after 4 DRAIN cycles
    b_rst_n = 1'b1;
    b_cv = 1'b1; b_inst = EBREAK; b_pc = 64'h8000_0400; b_a0 = 64'h55;
    b_busy = 1'b1; b_ready = 1'b1;
    qb.push_back('{code: 64'h55, pc: 64'h8000_0400, to: 1'b1});
    step();
    b_cv = 1'b0; b_inst = NOP;
    dcyc = 0;
    for (int k = 0; k < 20 && !b_hv; k++) begin
      dcyc++;
      step();
    end
    chk("timeout_drain_cycles", 64'(dcyc), 64'd4);
    chk("timeout_flag", {63'd0, b_to}, 64'd1);
    step();
    chk("timeout_halted", {63'd0, b_hv}, 64'd0);

    // DUT B: lsu_busy drops exactly in the 4th DRAIN cycle -> no timeout
    b_rst_n = 1'b0;
    step();
    b_rst_n = 1'b1;
    b_cv = 1'b1; b_inst = EBREAK; b_pc = 64'h8000_0404; b_a0 = 64'h66; b_busy = 1'b1;
    qb.push_back('{code: 64'h66, pc: 64'h8000_0404, to: 1'b0});
    step();
    b_cv = 1'b0; b_inst = NOP;
    dcyc = 0;
    for (int k = 0; k < 20 && !b_hv; k++) begin
      dcyc++;
      b_busy = (dcyc < 4);
      step();
    end
    chk("edge_drain_cycles", 64'(dcyc), 64'd4);
    chk("edge_timeout_low", {63'd0, b_to}, 64'd0);
    step();
    step();

    chk("sb_a_drained", 64'(qa.size()), 64'd0);
    chk("sb_b_drained", 64'(qb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ebreak_halt_ctrl.md
EBREAK_HALT_CTRL -- requirements
Module: ebreak_halt_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning datapath width of pc and a0.
REQ-002 SHALL have parameter DRAIN_MAX, default 255, meaning max cycles waited for lsu_busy to clear.
REQ-003 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port commit_valid  input  1  one instruction retires this cycle.
REQ-006 SHALL have port commit_inst  input  32  retiring instruction word.
REQ-007 SHALL have port commit_pc  input  XLEN  retiring pc.
REQ-008 SHALL have port a0  input  XLEN  current architectural x10, sampled on the ebreak commit.
REQ-009 SHALL have port lsu_busy  input  1  outstanding memory transaction.
REQ-010 SHALL have port freeze  output  1  stall fetch/commit.
REQ-011 SHALL have port halt_valid  output  1  halt report offered to the testbench.
REQ-012 SHALL have port halt_ready  input  1  testbench accepts the report.
REQ-013 SHALL have port halt_code, halt_pc  output  XLEN each  captured a0 and ebreak pc.
REQ-014 SHALL have port halt_timeout  output  1  drain exceeded DRAIN_MAX.
REQ-015 SHALL have port cycle_cnt, instret_cnt  output  64 each  perf counters (see Configuration).

Function
REQ-016 SHALL detect ebreak when commit_valid=1 and commit_inst==32'h0010_0073 in state RUN.
REQ-017 SHALL implement FSM RUN -> DRAIN -> REPORT -> HALTED.
- RUN: freeze=0; on ebreak commit capture a0 into halt_code and commit_pc into halt_pc, go DRAIN next cycle.
- DRAIN: freeze=1; drain counter increments each cycle; lsu_busy=0 -> REPORT; counter==DRAIN_MAX with lsu_busy=1 -> set halt_timeout, REPORT.
- REPORT: halt_valid=1, halt_code/halt_pc/halt_timeout stable; halt_valid&halt_ready -> HALTED.
- HALTED: freeze=1, halt_valid=0; exit only by reset.
REQ-018 SHALL assert freeze combinationally in the ebreak commit cycle (freeze = state!=RUN or ebreak detected).
REQ-019 SHALL hold halt_valid asserted without glitch until handshake; halt_ready while not REPORT ignored.
REQ-020 SHALL ignore commit_valid in DRAIN, REPORT, HALTED (no recapture, no count).
REQ-021 SHALL take lsu_busy=0 in the first DRAIN cycle as immediate REPORT entry (ebreak commit to halt_valid = 2 cycles minimum).
REQ-022 SHALL treat non-ebreak encodings (e.g. ecall 32'h0000_0073) as ordinary retirements.

Reset
REQ-023 SHALL on reset_n=0 asynchronously enter RUN and clear freeze, halt_valid, halt_code, halt_pc, halt_timeout, drain counter, cycle_cnt, instret_cnt to 0.
REQ-024 SHALL on reset mid-DRAIN or mid-REPORT abandon the report with halt_valid low in the reset cycle.

Configuration
REQ-025 SHALL compile perf counters only when NPC_HALT_PERF_CNT_EN is defined: cycle_cnt +1 every cycle not HALTED, instret_cnt +1 per commit_valid in RUN including ebreak; 64-bit wrap to 0.
REQ-026 SHALL without NPC_HALT_PERF_CNT_EN tie cycle_cnt and instret_cnt to 0 with no counter flops.

Verification
REQ-027 SHALL cover: ebreak at pc 0x8000_0010, a0=0, lsu_busy=0, halt_ready=1 -> halt_valid 2 cycles later, halt_code=0, halt_pc=0x8000_0010, then HALTED.
REQ-028 SHALL cover: ebreak with a0=1, lsu_busy high 5 cycles, halt_ready low 3 REPORT cycles -> halt_valid after busy drops, held 4 cycles, halt_code=1, halt_timeout=0.
REQ-029 SHALL cover: DRAIN_MAX=4, lsu_busy stuck 1 -> REPORT after 4 DRAIN cycles, halt_timeout=1.
REQ-030 SHALL cover: second ebreak with a0=7 committed during DRAIN -> halt_code unchanged, instret_cnt unchanged.
REQ-031 SHALL cover: reset_n low during REPORT -> immediate halt_valid=0, freeze=0, all counters 0, normal RUN afterward.
REQ-032 SHALL cover: with NPC_HALT_PERF_CNT_EN, 10 commits over 20 cycles then ebreak -> instret_cnt=11, cycle_cnt frozen on HALTED entry.
